// File: rtl/instr_fetch_responder_if.sv
// Fetch request/response bus between the PC unit (master) and the
// instruction-memory responder (slave): valid/ready request carrying a
// byte address, valid/ready response carrying the word and a fault code.
interface instr_fetch_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_instr,
    input  rsp_fault
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_instr,
    output rsp_fault
  );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction-memory responder for the CPU fetch path. Accepts a byte-address
// fetch, returns the 32-bit word one cycle after acceptance, flags misaligned
// and out-of-range addresses, and offers a load port for program words.
module instr_fetch_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  instr_fetch_responder_if.slave fetch_if,
  input  logic                  ld_en_i,
  input  logic [DEPTH_LOG2-1:0] ld_addr_i,
  input  logic [31:0]           ld_data_i,
  output logic [31:0]           fetch_count_o
);

  localparam int          DEPTH          = 1 << DEPTH_LOG2;
  // Byte span covered by the array; offsets at or above this are out of range.
  localparam logic [31:0] SPAN_BYTES     = 32'd4 << DEPTH_LOG2;
  localparam logic [1:0]  FAULT_OK       = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_RANGE    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                  state_q;
  logic [31:0]             mem_q [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [1:0]              fault_q;
  logic                    rsp_valid_q;
  logic [31:0]             rsp_instr_q;
  logic [1:0]              rsp_fault_q;
  logic [31:0]             fetch_count_q;

  logic [31:0]             offset_d;
  logic [1:0]              fault_d;
  logic [DEPTH_LOG2-1:0]   idx_d;
  logic                    req_ready_s;
  logic                    accept_s;
  logic                    done_ok_s;

  // Address decode: wrapping offset from base, misalignment wins over range.
  always_comb begin
    offset_d = fetch_if.req_addr - BASE_ADDR;
    idx_d    = offset_d[DEPTH_LOG2+1:2];
    if (fetch_if.req_addr[1:0] != 2'b00) begin
      fault_d = FAULT_MISALIGN;
    end else if (offset_d >= SPAN_BYTES) begin
      fault_d = FAULT_RANGE;
    end else begin
      fault_d = FAULT_OK;
    end
  end

  // Handshake qualifiers: ready in IDLE, or in HOLD when the response drains.
  always_comb begin
    req_ready_s = (state_q == ST_IDLE) ||
                  ((state_q == ST_HOLD) && fetch_if.rsp_ready);
    accept_s    = fetch_if.req_valid && req_ready_s;
    done_ok_s   = rsp_valid_q && fetch_if.rsp_ready && (rsp_fault_q == FAULT_OK);
  end

  // Program array write port; never reset, honoured in every state.
  always_ff @(posedge clk_i) begin
    if (ld_en_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  // Fetch FSM with registered response outputs and completion counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      fault_q       <= FAULT_OK;
      rsp_valid_q   <= 1'b0;
      rsp_instr_q   <= 32'd0;
      rsp_fault_q   <= FAULT_OK;
      fetch_count_q <= 32'd0;
    end else begin
      if (done_ok_s) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            idx_q   <= idx_d;
            fault_q <= fault_d;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Array read uses the pre-edge contents, so a same-edge load
          // to this index is seen only by a later fetch.
          rsp_instr_q <= (fault_q == FAULT_OK) ? mem_q[idx_q] : 32'd0;
          rsp_fault_q <= fault_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (fetch_if.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (fetch_if.req_valid) begin
              idx_q   <= idx_d;
              fault_q <= fault_d;
              state_q <= ST_BUSY;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign fetch_if.req_ready = req_ready_s;
  assign fetch_if.rsp_valid = rsp_valid_q;
  assign fetch_if.rsp_instr = rsp_instr_q;
  assign fetch_if.rsp_fault = rsp_fault_q;
  assign fetch_count_o      = fetch_count_q;

endmodule

// File: doc/instr_fetch_responder.md
# instr_fetch_responder

Instruction-memory responder for the single-cycle CPU's fetch path: sits on the far side of the PC unit. It accepts a byte-address fetch request, and returns the 32-bit instruction word one cycle later through a valid/ready response. It also flags misaligned and out-of-range addresses, and provides a write port for loading program words before or during simulation.

## Interface
- BASE_ADDR, 32'h0000_3000, byte address of word 0 (the PC reset vector)
- DEPTH_LOG2, 10, log2 of the number of 32-bit words in the array (default 1024 words)

- Clk  in  1  single clock; all state changes on its rising edge
- ReSetN  in  1  reset, synchronous, active-low
- ReqValid  in  1  fetch request present
- ReqReady  out  1  responder can accept a request this cycle
- ReqAddr  in  32  byte address to fetch (the PC)
- RspValid  out  1  response word and fault code valid
- RspReady  in  1  consumer takes the response this cycle
- RspInstr  out  32  fetched instruction; 0 when faulted
- RspFault  out  2  00 ok, 01 misaligned, 10 out of range
- LdEn  in  1  load-port write enable
- LdAddr  in  DEPTH_LOG2  word index to write
- LdData  in  32  word to write
- FetchCount  out  32  count of completed non-faulted responses

## Operation
- States: IDLE (nothing pending), BUSY (array read in flight), HOLD (response presented).
- ReqReady = (state==IDLE) | (state==HOLD & RspReady). This is combinational from state and RspReady.
- A request is accepted when ReqValid & ReqReady at a rising edge. On acceptance, the address, word index and fault code are registered and the state moves to BUSY.
- BUSY always moves to HOLD on the next edge. RspInstr, RspFault and RspValid=1 are registered on that edge.
- HOLD transitions:
  - RspReady & ReqValid: move to BUSY; the new request is accepted and RspValid=0 next cycle.
  - RspReady & !ReqValid: move to IDLE.
  - !RspReady: stay in HOLD; all response outputs are held stable.
- Fault decode, done at acceptance:
  - offset = ReqAddr - BASE_ADDR, computed as a 32-bit unsigned subtraction that wraps modulo 2^32.
  - Misaligned if ReqAddr[1:0] != 0. This has priority over range.
  - Otherwise out of range if offset >= 4 << DEPTH_LOG2. An address below BASE_ADDR wraps to a large offset and is therefore out of range.
  - Word index = offset[DEPTH_LOG2+1:2].
- A faulted request does not read the array. It takes the same latency, with RspInstr=0.
- Load port: when LdEn=1, mem[LdAddr] <= LdData on the edge. It is honoured in any state. If LdEn writes the same index on the same edge that a BUSY read samples it, the read returns the old word (read-before-write).
- FetchCount increments by 1 on each edge where RspValid & RspReady & RspFault==00. It wraps from FFFF_FFFF to 0.
- Reset (ReSetN=0 at an edge): state=IDLE, RspValid=0, RspInstr=0, RspFault=00, FetchCount=0. Array contents are not cleared.
- Reset mid-operation discards any in-flight or held response without counting it. A request presented in the same cycle as reset is not accepted. LdEn during reset is still honoured.

## Timing
- Acceptance at edge N gives RspValid=1 after edge N+1, i.e. one cycle of latency from acceptance to response.
- Sustained throughput is one response per 2 cycles with RspReady tied high.
- ReqReady is 1 out of reset (IDLE) and 0 in BUSY.
- RspInstr and RspFault change only on the BUSY→HOLD edge or on reset. They are otherwise stable while RspValid=1.
- FetchCount updates on the edge that completes the handshake and is visible the following cycle.

## Test plan
- Reset then sequential fetch: load mem[0]=24020005, mem[1]=24030007. With RspReady=1, request 0x3000 then 0x3004. Required: two responses, 24020005 then 24030007, each RspValid one cycle after acceptance, RspFault=00, FetchCount=2.
- Backpressure: request 0x3000 with RspReady=0 for 3 cycles. Required: RspValid, RspInstr and RspFault held stable and ReqReady=0 throughout. Raising RspReady together with ReqValid (addr 0x3004) gives a same-cycle accept, and FetchCount increments once.
- Faults:
  - 0x3002 gives RspFault=01, RspInstr=0.
  - 0x2FFC (wraps below base) gives 10.
  - 0x4000 with DEPTH_LOG2=10 gives 10.
  - 0x3FFC is ok.
  - FetchCount is unchanged by the faulted responses.
- Load/read collision: with mem[3]=AAAA_AAAA, accept 0x300C, and on the BUSY edge LdEn writes mem[3]=5555_5555. Required: the response is AAAA_AAAA, and a refetch returns 5555_5555.
- Reset mid-operation: accept a request, then drive ReSetN=0 in BUSY. Required: the next cycle has RspValid=0, ReqReady=1, FetchCount=0, and no response is ever presented for the discarded request.
- Counter wrap: reach FetchCount=FFFF_FFFF (the bench may preload it via hierarchical force), then complete one ok fetch. Required: FetchCount=0.
